// File: rtl/operand_bypass.sv
// Operand bypass stage between the register-file read ports and the execute stage.
// The register file returns data one cycle after sampling the address, and that data
// does not include a write that commits on the same edge. This block records the most
// recent write and substitutes the newest value. Reads of r15 return the architectural
// PC (iaddr + PC_OFS). A saturating counter tallies substitutions for debug.
//
// Handshake: in_valid marks in1/in2 as a real read request. stall=1 means the execute
// stage is not accepting, so the captured request (address and valid) is held. A
// request is accepted on any posedge with stall=0, and its operands are presented one
// cycle later with op_valid=1.
module operand_bypass #(
  parameter int W      = 32,
  parameter int PC_OFS = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [3:0]       in1,
  input  logic [3:0]       in2,
  input  logic             we,
  input  logic [3:0]       wa,
  input  logic [W-1:0]     wd,
  input  logic [W-1:0]     rf_out1,
  input  logic [W-1:0]     rf_out2,
  input  logic [W-1:0]     iaddr,
  output logic [W-1:0]     op1,
  output logic [W-1:0]     op2,
  output logic             op_valid,
  output logic [CNT_W-1:0] fwd_count
);

  localparam logic [3:0]   PC_REG   = 4'd15;
  localparam logic [W-1:0] PC_OFS_W = W'(PC_OFS);

  logic [3:0]       r_a1;
  logic [3:0]       r_a2;
  logic             r_v;
  logic             r_h_we;
  logic [3:0]       r_h_wa;
  logic [W-1:0]     r_h_wd;
  logic [CNT_W-1:0] r_fwd_count;

  logic [W-1:0]     w_pc;
  logic [W-1:0]     w_op1;
  logic [W-1:0]     w_op2;
  logic             w_fwd1;
  logic             w_fwd2;
  logic [1:0]       w_inc;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_cnt_next;

  // Priority resolution for one port: PC, then current write, then history, then RF.
  // Bit W of the result flags that a write-history substitution was made.
  function automatic logic [W:0] resolve(
    input logic [3:0]   a,
    input logic [W-1:0] rf,
    input logic [W-1:0] pc,
    input logic         cur_we,
    input logic [3:0]   cur_wa,
    input logic [W-1:0] cur_wd,
    input logic         hist_we,
    input logic [3:0]   hist_wa,
    input logic [W-1:0] hist_wd
  );
    logic [W:0] res;
    res = {1'b0, rf};
    if (a == PC_REG) begin
      res = {1'b0, pc};
    end else if (cur_we && (cur_wa == a) && (cur_wa != PC_REG)) begin
      res = {1'b1, cur_wd};
    end else if (hist_we && (hist_wa == a)) begin
      res = {1'b1, hist_wd};
    end
    return res;
  endfunction

  // Capture the request (held while stalled) and record every edge's write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a1   <= 4'd0;
      r_a2   <= 4'd0;
      r_v    <= 1'b0;
      r_h_we <= 1'b0;
      r_h_wa <= 4'd0;
      r_h_wd <= '0;
    end else begin
      if (!stall) begin
        r_a1 <= in1;
        r_a2 <= in2;
        r_v  <= in_valid;
      end
      // r15 writes belong to the PC module and are never replayed from history.
      r_h_we <= we & (wa != PC_REG);
      r_h_wa <= wa;
      r_h_wd <= wd;
    end
  end

  // Resolve both operands from the captured addresses.
  always_comb begin
    w_pc = iaddr + PC_OFS_W;
    {w_fwd1, w_op1} = resolve(r_a1, rf_out1, w_pc, we, wa, wd, r_h_we, r_h_wa, r_h_wd);
    {w_fwd2, w_op2} = resolve(r_a2, rf_out2, w_pc, we, wa, wd, r_h_we, r_h_wa, r_h_wd);
  end

  // Count substitutions on accepted operands; saturate instead of wrapping.
  always_comb begin
    w_inc = 2'd0;
    if (r_v && !stall) begin
      w_inc = {1'b0, w_fwd1} + {1'b0, w_fwd2};
    end
    w_sum      = {1'b0, r_fwd_count} + {{(CNT_W-1){1'b0}}, w_inc};
    w_cnt_next = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  end

  // Forward-event counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fwd_count <= '0;
    end else begin
      r_fwd_count <= w_cnt_next;
    end
  end

  assign op1       = w_op1;
  assign op2       = w_op2;
  assign op_valid  = r_v;
  assign fwd_count = r_fwd_count;

endmodule

// File: tb/tb_operand_bypass.sv
// Directed bench for operand_bypass: a table of per-cycle vectors with hand-computed
// outputs, followed by hand-written counter-saturation and mid-stall reset sequences.
module tb_operand_bypass;

  localparam int W     = 32;
  localparam int CNT_W = 16;

  // Clock / reset
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid, stall, we;
  logic [3:0]       in1, in2, wa;
  logic [W-1:0]     wd, rf_out1, rf_out2, iaddr;
  logic [W-1:0]     op1, op2;
  logic             op_valid;
  logic [CNT_W-1:0] fwd_count;

  operand_bypass #(.W(W), .PC_OFS(8), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .stall    (stall),
    .in1      (in1),
    .in2      (in2),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .rf_out1  (rf_out1),
    .rf_out2  (rf_out2),
    .iaddr    (iaddr),
    .op1      (op1),
    .op2      (op2),
    .op_valid (op_valid),
    .fwd_count(fwd_count)
  );

  typedef struct {
    logic         v;
    logic         st;
    logic [3:0]   a1;
    logic [3:0]   a2;
    logic         we;
    logic [3:0]   wa;
    logic [W-1:0] wd;
    logic [W-1:0] rf1;
    logic [W-1:0] rf2;
    logic [W-1:0] ia;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    logic         ev;
    logic [15:0]  ec;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl[NV];

  int checks = 0;
  int errors = 0;

  // Scoreboard compare
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver: present one cycle's inputs
  task automatic drive(input vec_t t);
    in_valid = t.v;  stall = t.st;
    in1 = t.a1;      in2 = t.a2;
    we = t.we;       wa = t.wa;      wd = t.wd;
    rf_out1 = t.rf1; rf_out2 = t.rf2; iaddr = t.ia;
  endtask

  function automatic vec_t mk(
    input logic v, input logic st, input logic [3:0] a1, input logic [3:0] a2,
    input logic w, input logic [3:0] a, input logic [W-1:0] d,
    input logic [W-1:0] r1, input logic [W-1:0] r2, input logic [W-1:0] ia,
    input logic [W-1:0] e1, input logic [W-1:0] e2, input logic ev, input logic [15:0] ec);
    vec_t t;
    t.v = v; t.st = st; t.a1 = a1; t.a2 = a2; t.we = w; t.wa = a; t.wd = d;
    t.rf1 = r1; t.rf2 = r2; t.ia = ia; t.e1 = e1; t.e2 = e2; t.ev = ev; t.ec = ec;
    return t;
  endfunction

  initial begin
    //                v  st a1 a2 we wa wd            rf1           rf2     iaddr   e1            e2            ev ec
    tbl[0]  = mk(1, 0, 3, 0,  1, 3,  32'h11111111, 32'h0,        32'h0,  32'h0,   32'h0,        32'h0,        0, 16'd0);
    tbl[1]  = mk(1, 0, 3, 0,  0, 0,  32'h0,        32'hDEADBEEF, 32'h22, 32'h0,   32'h11111111, 32'h22,       1, 16'd0);
    tbl[2]  = mk(1, 0, 3, 0,  0, 0,  32'h0,        32'hABCD0000, 32'h33, 32'h0,   32'hABCD0000, 32'h33,       1, 16'd1);
    tbl[3]  = mk(1, 0, 3, 15, 0, 0,  32'h0,        32'hABCD0000, 32'h44, 32'h100, 32'hABCD0000, 32'h44,       1, 16'd1);
    tbl[4]  = mk(1, 0, 5, 15, 1, 15, 32'hDEAD,     32'hABCD0000, 32'h55, 32'h100, 32'hABCD0000, 32'h108,      1, 16'd1);
    tbl[5]  = mk(1, 0, 5, 15, 1, 5,  32'h5,        32'h99,       32'h77, 32'h200, 32'h5,        32'h208,      1, 16'd1);
    tbl[6]  = mk(1, 0, 5, 15, 1, 5,  32'h6,        32'h99,       32'h77, 32'h200, 32'h6,        32'h208,      1, 16'd2);
    tbl[7]  = mk(1, 0, 5, 5,  0, 0,  32'h0,        32'h99,       32'h88, 32'h200, 32'h6,        32'h208,      1, 16'd3);
    tbl[8]  = mk(1, 0, 2, 2,  0, 0,  32'h0,        32'h99,       32'h88, 32'h200, 32'h99,       32'h88,       1, 16'd4);
    tbl[9]  = mk(1, 1, 2, 2,  1, 2,  32'h1,        32'h50,       32'h50, 32'h200, 32'h1,        32'h1,        1, 16'd4);
    tbl[10] = mk(1, 1, 2, 2,  1, 2,  32'h2,        32'h50,       32'h50, 32'h200, 32'h2,        32'h2,        1, 16'd4);
    tbl[11] = mk(1, 1, 2, 2,  1, 2,  32'h3,        32'h50,       32'h50, 32'h200, 32'h3,        32'h3,        1, 16'd4);
    tbl[12] = mk(0, 0, 7, 8,  0, 0,  32'h0,        32'h50,       32'h50, 32'h200, 32'h3,        32'h3,        1, 16'd4);
    tbl[13] = mk(0, 0, 0, 0,  1, 7,  32'hAA,       32'h70,       32'h80, 32'h200, 32'hAA,       32'h80,       0, 16'd6);
    tbl[14] = mk(0, 0, 0, 0,  0, 0,  32'h0,        32'h1,        32'h2,  32'h200, 32'h1,        32'h2,        0, 16'd6);

    // Reset state
    drive(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'hC0FFEE, 32'hBEEF, 32'h0, 32'h0, 32'h0, 0, 16'd0));
    reset = 1'b1;
    #1;
    check("reset_op_valid", {31'd0, op_valid}, 32'd0);
    check("reset_fwd_count", {16'd0, fwd_count}, 32'd0);
    check("reset_op1_rf", op1, 32'hC0FFEE);
    check("reset_op2_rf", op2, 32'hBEEF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors: drive on negedge, compare 1 time unit later
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("vec%0d_op1", i), op1, tbl[i].e1);
      check($sformatf("vec%0d_op2", i), op2, tbl[i].e2);
      check($sformatf("vec%0d_op_valid", i), {31'd0, op_valid}, {31'd0, tbl[i].ev});
      check($sformatf("vec%0d_fwd_count", i), {16'd0, fwd_count}, {16'd0, tbl[i].ec});
    end

    // Saturation: reset, then both ports forward the current write every cycle
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    drive(mk(1, 0, 3, 3, 1, 3, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 16'd0));
    @(posedge clk);                 // request captured, op_valid rises
    repeat (32767) @(posedge clk);  // +2 per edge -> 0xFFFE
    @(negedge clk);
    check("sat_preload", {16'd0, fwd_count}, 32'h0000FFFE);
    check("sat_op1_fwd", op1, 32'h1234);
    @(negedge clk);
    check("sat_reach_max", {16'd0, fwd_count}, 32'h0000FFFF);
    @(negedge clk);
    check("sat_hold_max", {16'd0, fwd_count}, 32'h0000FFFF);
    check("sat_op_valid", {31'd0, op_valid}, 32'd1);

    // Reset asserted mid-stall, between clock edges
    stall = 1'b1;
    we = 1'b0;
    rf_out1 = 32'h600D;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_fwd_count", {16'd0, fwd_count}, 32'd0);
    check("midrst_op_valid", {31'd0, op_valid}, 32'd0);
    check("midrst_op1_rf", op1, 32'h600D);
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check("post_rst_count", {16'd0, fwd_count}, 32'd0);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
